// File: rtl/lcd_pkg.sv
// Shared constants for the 16x2 text-LCD path.
// Holds display geometry, the fill character, host command codes and the
// frame-buffer FSM state encoding. Imported by the buffer, its RAM and the
// LCD controller so all of them agree on geometry.
package lcd_pkg;

    localparam int unsigned COLS   = 16;
    localparam int unsigned ROWS   = 2;
    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned ADDR_W = 5;

    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic [1:0] {
        CMD_CHAR      = 2'b00,
        CMD_NEWLINE   = 2'b01,
        CMD_CLEAR     = 2'b10,
        CMD_BACKSPACE = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character RAM holding the display image.
// Ports:
//   lcdclk, resetn        clock / async active-low reset (read register only)
//   we, waddr, wdata      synchronous write port
//   raddr, rdata          registered read port, 1-cycle latency
// A read and write to the same address in one cycle returns the old data.
module lcd_char_ram
    import lcd_pkg::*;
(
    input  logic              lcdclk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_d;
    logic [7:0] rdata_q;

    // Read from the pre-edge array contents, which gives old-data on collision.
    always_comb begin
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge lcdclk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lcd_text_buffer.sv
// Character frame buffer feeding the 16x2 text-LCD controller.
// Ports:
//   lcdclk, resetn            clock / async active-low reset
//   wr_valid/wr_ready         host command handshake
//   wr_cmd, wr_char           command (char/newline/clear/backspace) and code
//   rd_addr, rd_data          controller read port, registered, 1-cycle latency
//   refresh_req/refresh_ack   image-changed flag and its acknowledge
//   cursor_row, cursor_col    current cursor position
//   busy                      clear sweep in progress
module lcd_text_buffer
    import lcd_pkg::*;
(
    input  logic              lcdclk,
    input  logic              resetn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_cmd,
    input  logic [7:0]        wr_char,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              refresh_req,
    input  logic              refresh_ack,
    output logic              cursor_row,
    output logic [3:0]        cursor_col,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;   // {row, col}
    logic              refresh_q, refresh_d;

    cmd_e              cmd;
    logic              accept;
    logic              change;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    assign cmd    = cmd_e'(wr_cmd);
    assign accept = wr_valid && wr_ready;

    // State register
    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: if (idx_q == LAST_ADDR)             state_d = ST_IDLE;
            ST_IDLE:  if (accept && (cmd == CMD_CLEAR))   state_d = ST_CLEAR;
            default:                                      state_d = ST_CLEAR;
        endcase
    end

    // FSM outputs
    always_comb begin
        wr_ready = (state_q == ST_IDLE);
        busy     = (state_q == ST_CLEAR);
    end

    // Datapath: sweep index, cursor, RAM write port, change detect.
    // The cursor is kept as a flat 5-bit address so that +1 / -1 give the
    // row rollover and the (1,15)<->(0,0) wrap without extra compares.
    always_comb begin
        idx_d     = '0;
        cursor_d  = cursor_q;
        ram_we    = 1'b0;
        ram_waddr = cursor_q;
        ram_wdata = BLANK;
        change    = 1'b0;

        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = idx_q;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST_ADDR) begin
                cursor_d = '0;
                change   = 1'b1;
            end
        end else if (accept) begin
            case (cmd)
                CMD_CHAR: begin
                    ram_we    = 1'b1;
                    ram_wdata = wr_char;
                    cursor_d  = cursor_q + 1'b1;
                    change    = 1'b1;
                end
                CMD_NEWLINE: begin
                    cursor_d = {~cursor_q[ADDR_W-1], {(ADDR_W-1){1'b0}}};
                end
                CMD_CLEAR: begin
                    idx_d = '0;
                end
                CMD_BACKSPACE: begin
                    if (cursor_q != '0) begin
                        cursor_d  = cursor_q - 1'b1;
                        ram_we    = 1'b1;
                        ram_waddr = cursor_q - 1'b1;
                        change    = 1'b1;
                    end
                end
            endcase
        end

        // A content change in the same cycle as an ack keeps the request up.
        if (change) begin
            refresh_d = 1'b1;
        end else if (refresh_ack) begin
            refresh_d = 1'b0;
        end else begin
            refresh_d = refresh_q;
        end
    end

    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            idx_q     <= '0;
            cursor_q  <= '0;
            refresh_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cursor_q  <= cursor_d;
            refresh_q <= refresh_d;
        end
    end

    assign refresh_req = refresh_q;
    assign cursor_row  = cursor_q[ADDR_W-1];
    assign cursor_col  = cursor_q[ADDR_W-2:0];

    lcd_char_ram u_ram (
        .lcdclk (lcdclk),
        .resetn (resetn),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

endmodule
